// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: arbitrates two valid/ready clients onto one non-pipelined AHB-Lite RAM port.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise port 0 wins ties.
module ahb_ram_arbiter #(
    parameter int          MEMWIDTH  = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [2:0]  req0_size,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [2:0]  req1_size,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic        rsp0_err,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [31:0] rsp1_rdata,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic        HREADY,
    input  logic        HREADYOUT,
    input  logic [31:0] HRDATA
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t      state;
    logic        last_grant, owner, tie0, grant0, grant1, sel_write, legal;
    logic [31:0] sel_addr, sel_wdata, wdata_q;
    logic [2:0]  sel_size;
    logic [32:0] addr_ext, lo, hi;
`ifdef ARB_ROUND_ROBIN_EN
    assign tie0 = last_grant;
`else
    logic unused_last;
    assign unused_last = last_grant;
    assign tie0 = 1'b1;
`endif
    assign grant0     = req0_valid && (!req1_valid || tie0);
    assign grant1     = req1_valid && !grant0;
    assign req0_ready = state == IDLE && grant0;
    assign req1_ready = state == IDLE && grant1;
    assign sel_write  = grant1 ? req1_write : req0_write;
    assign sel_addr   = grant1 ? req1_addr  : req0_addr;
    assign sel_size   = grant1 ? req1_size  : req0_size;
    assign sel_wdata  = grant1 ? req1_wdata : req0_wdata;
    assign addr_ext   = {1'b0, sel_addr};
    assign lo         = {1'b0, BASE_ADDR};
    assign hi         = lo + (33'd1 << MEMWIDTH);
    // Range plus natural alignment; anything else is answered with an error and never reaches the bus.
    assign legal = addr_ext >= lo && addr_ext < hi && sel_size <= 3'd2 &&
                   !(sel_size == 3'd1 && sel_addr[0]) &&
                   !(sel_size == 3'd2 && sel_addr[1:0] != 2'b00);
    assign HREADY = HREADYOUT;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wdata_q    <= 32'h0;
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= 32'h0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= 32'h0;
            HSEL       <= 1'b0;
            HADDR      <= 32'h0;
            HTRANS     <= 2'b00;
            HWRITE     <= 1'b0;
            HSIZE      <= 3'b000;
            HWDATA     <= 32'h0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            case (state)
                IDLE: if (grant0 || grant1) begin
                    last_grant <= grant1;
                    owner      <= grant1;
                    if (legal) begin
                        state   <= ADDR;
                        HSEL    <= 1'b1;
                        HTRANS  <= 2'b10;
                        HADDR   <= sel_addr;
                        HWRITE  <= sel_write;
                        HSIZE   <= sel_size;
                        wdata_q <= sel_wdata;
                    end else begin
                        rsp0_valid <= grant0;
                        rsp0_err   <= grant0;
                        rsp1_valid <= grant1;
                        rsp1_err   <= grant1;
                    end
                end
                ADDR: if (HREADYOUT) begin
                    state  <= DATA;
                    HSEL   <= 1'b0;
                    HTRANS <= 2'b00;
                    HWDATA <= wdata_q;
                end
                DATA: if (HREADYOUT) begin
                    state      <= IDLE;
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    if (!HWRITE && !owner) rsp0_rdata <= HRDATA;
                    if (!HWRITE && owner) rsp1_rdata <= HRDATA;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// tb_ahb_ram_arbiter: directed vectors, arbitration and reset sequences, then random traffic
// against a byte-array memory model with per-port expected-response queues.
module tb_ahb_ram_arbiter;
    localparam int          MW   = 14;
    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {bit err; bit rd; logic [31:0] rdata;} sb_t;
    typedef struct {bit p; bit w; logic [31:0] a; logic [2:0] s; logic [31:0] d; int waits; bit err; logic [31:0] rd;} vec_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic req0_valid, req0_ready, req0_write, req1_valid, req1_ready, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [2:0]  req0_size, req1_size;
    logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic HSEL, HWRITE, HREADY, HREADYOUT;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    sb_t  q[2][$];
    bit   gq[$];
    logic [7:0]  ref_mem [0:16383];
    logic [31:0] smem [0:4095];
    logic [31:0] last_rd [2];
    bit   m_last, hs0, hs1, rnd;
    int   wait_n, checks, errors, nonseq_cnt;
    int   rsp_cnt [2];

    ahb_ram_arbiter #(.MEMWIDTH(MW), .BASE_ADDR(BASE)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_size(req0_size), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_size(req1_size), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // RAM slave: word array, byte-lane writes at the end of the data phase, optional wait states.
    logic        dph, dp_write;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    int          wcnt;
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] a, input logic [2:0] s);
        logic [3:0] m;
        m = s == 3'd0 ? 4'b0001 << a : s == 3'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = wd[8*i +: 8];
        return old;
    endfunction
    assign HREADYOUT = !(dph && wcnt != 0);
    assign HRDATA    = (dph && !dp_write) ? smem[dp_addr[13:2]] : 32'h0;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph  <= 1'b0;
            wcnt <= 0;
        end else if (dph && wcnt != 0) begin
            wcnt <= wcnt - 1;
        end else begin
            if (dph && dp_write) smem[dp_addr[13:2]] <= merge(smem[dp_addr[13:2]], HWDATA, dp_addr[1:0], dp_size);
            dph <= HSEL && HTRANS[1] && HREADY;
            if (HSEL && HTRANS[1] && HREADY) begin
                dp_addr  <= HADDR;
                dp_write <= HWRITE;
                dp_size  <= HSIZE;
                wcnt     <= rnd ? int'($urandom_range(0, 2)) : wait_n;
            end
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_f(input logic [31:0] a, input logic [2:0] s);
        return a >= BASE && (a - BASE) < (32'd1 << MW) &&
               (s == 3'd0 || (s == 3'd1 && !a[0]) || (s == 3'd2 && a[1:0] == 2'b00));
    endfunction

    task automatic sb_push(input int p, input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        sb_t e;
        int  b;
        e.err = !legal_f(a, s);
        e.rd = !w;
        e.rdata = 32'h0;
        if (!e.err) begin
            b = int'((a - BASE) & 32'h3FFF);
            if (w) for (int i = 0; i < (1 << s); i++) ref_mem[b+i] = d[8*((b+i)%4) +: 8];
            else begin
                b = b & ~3;
                e.rdata = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            end
        end
        q[p].push_back(e);
    endtask

    task automatic sb_rsp(input int p, input logic err, input logic [31:0] rd);
        sb_t e;
        rsp_cnt[p]++;
        chk(q[p].size() != 0, "rsp_expected", 32'(q[p].size()), 32'd1);
        if (q[p].size() == 0) return;
        e = q[p].pop_front();
        chk(err == e.err, "rsp_err", 32'(err), 32'(e.err));
        if (e.rd && !e.err) begin
            chk(rd == e.rdata, "rsp_rdata", rd, e.rdata);
            last_rd[p] = e.rdata;
        end else chk(rd == last_rd[p], "rdata_hold", rd, last_rd[p]);
    endtask

    // Monitor: grant order model, scoreboard push on handshake, pop on response.
    initial forever begin
        bit ew;
        @(negedge HCLK);
        if (!HRESETn) begin
            q[0].delete();
            q[1].delete();
            m_last = 1'b1;
            last_rd[0] = 32'h0;
            last_rd[1] = 32'h0;
            hs0 = 1'b0;
            hs1 = 1'b0;
        end else begin
            if (HTRANS == 2'b10) nonseq_cnt++;
            chk(HSEL == HTRANS[1] && !HTRANS[0], "bus_state", 32'({HSEL, HTRANS}), 32'({HTRANS[1], HTRANS[1], 1'b0}));
            if (rsp0_valid) sb_rsp(0, rsp0_err, rsp0_rdata);
            if (rsp1_valid) sb_rsp(1, rsp1_err, rsp1_rdata);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (req0_ready || req1_ready) begin
                ew = (req0_valid && req1_valid) ? (RR && !m_last) : req1_valid;
                chk(!(req0_ready && req1_ready) && (req1_ready ? req1_valid : req0_valid) && req1_ready == ew,
                    "grant", 32'({req1_ready, req0_ready}), ew ? 32'd2 : 32'd1);
                m_last = req1_ready;
                gq.push_back(req1_ready);
                if (req1_ready) sb_push(1, req1_write, req1_addr, req1_size, req1_wdata);
                else sb_push(0, req0_write, req0_addr, req0_size, req0_wdata);
            end
        end
    end

    task automatic drv(input int p, input logic v, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_size = s; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_size = s; req1_wdata = d;
        end
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        logic [2:0]  s;
        s = 3'($urandom_range(0, 6));
        if (s > 3'd3) s = 3'd2;
        a = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = s == 3'd2 ? {a[31:2], 2'b00} : s == 3'd1 ? {a[31:1], 1'b0} : a;
        drv(p, 1'b1, 1'($urandom_range(0, 1)), a, s, $urandom);
    endtask

    task automatic do_req(input vec_t v);
        bit hs, got;
        int lat, n0, exp_lat;
        exp_lat = v.err ? 1 : 3 + v.waits;
        wait_n = v.waits;
        n0 = nonseq_cnt;
        drv(int'(v.p), 1'b1, v.w, v.a, v.s, v.d);
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge HCLK);
            hs = v.p ? req1_ready : req0_ready;
            @(posedge HCLK);
            #1;
        end
        chk(hs, "handshake", 32'(hs), 32'd1);
        drv(int'(v.p), 1'b0, v.w, v.a, v.s, v.d);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge HCLK);
            lat++;
            got = v.p ? rsp1_valid : rsp0_valid;
        end
        chk(got && lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
        if (got) begin
            chk((v.p ? rsp1_err : rsp0_err) == v.err, "err", 32'(v.p ? rsp1_err : rsp0_err), 32'(v.err));
            if (!v.err && !v.w) chk((v.p ? rsp1_rdata : rsp0_rdata) == v.rd, "rdata", v.p ? rsp1_rdata : rsp0_rdata, v.rd);
            chk(nonseq_cnt - n0 == (v.err ? 0 : 1), "nonseq_cycles", 32'(nonseq_cnt - n0), v.err ? 32'd0 : 32'd1);
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv[15];
        bit   exp_g[$];
        int   r0, r1, c0, n0;
        bit   l, w, hs;
        HRESETn = 1'b0;
        rnd = 1'b0;
        wait_n = 0;
        drv(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h0;
        for (int i = 0; i < 4096; i++) smem[i] = 32'h0;
        tv[0]  = '{0, 1, 32'h10,   3'd2, 32'hDEADBEEF, 0, 0, 32'h0};
        tv[1]  = '{0, 0, 32'h10,   3'd2, 32'h0,        0, 0, 32'hDEADBEEF};
        tv[2]  = '{1, 1, 32'h10,   3'd2, 32'h11223344, 0, 0, 32'h0};
        tv[3]  = '{1, 1, 32'h13,   3'd0, 32'hAA000000, 0, 0, 32'h0};
        tv[4]  = '{1, 0, 32'h10,   3'd2, 32'h0,        0, 0, 32'hAA223344};
        tv[5]  = '{0, 0, 32'h4000, 3'd2, 32'h0,        0, 1, 32'h0};
        tv[6]  = '{0, 0, 32'h12,   3'd2, 32'h0,        0, 1, 32'h0};
        tv[7]  = '{0, 1, 32'h12,   3'd1, 32'h55660000, 0, 0, 32'h0};
        tv[8]  = '{1, 0, 32'h10,   3'd2, 32'h0,        0, 0, 32'h55663344};
        tv[9]  = '{0, 0, 32'h10,   3'd3, 32'h0,        0, 1, 32'h0};
        tv[10] = '{1, 1, 32'h11,   3'd1, 32'h00BBCC00, 0, 1, 32'h0};
        tv[11] = '{1, 1, 32'h3FFC, 3'd2, 32'hCAFEF00D, 0, 0, 32'h0};
        tv[12] = '{0, 0, 32'h3FFF, 3'd0, 32'h0,        2, 0, 32'hCAFEF00D};
        tv[13] = '{1, 0, 32'h3FFE, 3'd1, 32'h0,        1, 0, 32'hCAFEF00D};
        tv[14] = '{1, 1, 32'h3FFD, 3'd1, 32'h12345678, 0, 1, 32'h0};

        repeat (3) @(posedge HCLK);
        #1;
        chk({HSEL, HTRANS, HWRITE, HSIZE} == 7'h0, "reset_ctrl", 32'({HSEL, HTRANS, HWRITE, HSIZE}), 32'h0);
        chk(HADDR == 32'h0, "reset_haddr", HADDR, 32'h0);
        chk(HWDATA == 32'h0, "reset_hwdata", HWDATA, 32'h0);
        chk({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, req0_ready, req1_ready} == 6'h0, "reset_hs",
            32'({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, req0_ready, req1_ready}), 32'h0);
        chk(rsp0_rdata == 32'h0 && rsp1_rdata == 32'h0, "reset_rdata", rsp0_rdata | rsp1_rdata, 32'h0);
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            chk(HTRANS == 2'b00 && !HSEL && !req0_ready && !req1_ready && !rsp0_valid && !rsp1_valid,
                "idle_after_reset", 32'({HSEL, HTRANS, req0_ready, req1_ready}), 32'h0);
        end
        @(posedge HCLK);
        #1;

        foreach (tv[i]) do_req(tv[i]);

        // Both clients stay valid for four reads each.
        gq.delete();
        r0 = 4;
        r1 = 4;
        l = m_last;
        while (r0 + r1 > 0) begin
            w = (r0 > 0 && r1 > 0) ? (RR && !l) : (r1 > 0);
            exp_g.push_back(w);
            l = w;
            if (w) r1--;
            else r0--;
        end
        r0 = 4;
        r1 = 4;
        drv(0, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0);
        drv(1, 1'b1, 1'b0, 32'h3FFC, 3'd2, 32'h0);
        for (int c = 0; c < 100 && (req0_valid || req1_valid); c++) begin
            @(posedge HCLK);
            #1;
            if (hs0) r0--;
            if (hs1) r1--;
            if (r0 <= 0) req0_valid = 1'b0;
            if (r1 <= 0) req1_valid = 1'b0;
        end
        repeat (6) @(posedge HCLK);
        #1;
        chk(gq.size() == 8, "arb_count", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk(gq[i] == exp_g[i], "arb_order", 32'(gq[i]), 32'(exp_g[i]));

        // Reset asserted during the address phase drops the transfer.
        drv(0, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0);
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge HCLK);
            hs = req0_ready;
            @(posedge HCLK);
            #1;
        end
        req0_valid = 1'b0;
        chk(HTRANS == 2'b10 && HSEL, "mid_addr_phase", 32'({HSEL, HTRANS}), 32'h6);
        c0 = rsp_cnt[0];
        n0 = nonseq_cnt;
        HRESETn = 1'b0;
        #1;
        chk(!HSEL && HTRANS == 2'b00 && HADDR == 32'h0, "async_reset", 32'({HSEL, HTRANS}) | HADDR, 32'h0);
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (8) @(posedge HCLK);
        #1;
        chk(rsp_cnt[0] == c0, "no_rsp_after_reset", 32'(rsp_cnt[0]), 32'(c0));
        chk(nonseq_cnt == n0, "no_bus_after_reset", 32'(nonseq_cnt), 32'(n0));
        do_req('{0, 0, 32'h3FFC, 3'd2, 32'h0, 0, 0, 32'hCAFEF00D});

        // Random traffic with random wait states.
        rnd = 1'b1;
        c0 = rsp_cnt[0] + rsp_cnt[1];
        for (int c = 0; c < 3000; c++) begin
            @(posedge HCLK);
            #1;
            if (hs0) req0_valid = 1'b0;
            if (hs1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) == 0) rand_req(0);
            if (!req1_valid && $urandom_range(0, 2) == 0) rand_req(1);
        end
        for (int c = 0; c < 200 && (req0_valid || req1_valid); c++) begin
            @(posedge HCLK);
            #1;
            if (hs0) req0_valid = 1'b0;
            if (hs1) req1_valid = 1'b0;
        end
        repeat (12) @(posedge HCLK);
        #1;
        chk(!req0_valid && !req1_valid, "drain_handshake", 32'({req0_valid, req1_valid}), 32'h0);
        chk(q[0].size() == 0 && q[1].size() == 0, "drain_responses", 32'(q[0].size() + q[1].size()), 32'h0);
        chk(rsp_cnt[0] + rsp_cnt[1] - c0 > 200, "random_activity", 32'(rsp_cnt[0] + rsp_cnt[1] - c0), 32'd201);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
